m_mem_access: RTL and testbench
===============================

Name: m_mem_access

Overview:
- M-stage data-memory access unit. Sits between the M pipeline register and the M/W pipeline register.
- Turns the M-stage load/store into a req/ack transaction on the external data bus, and stalls the pipeline until the bus answers.
- Produces the sign/zero-extended load word (dm_out) that the M/W register captures as its DM input.
- Reports alignment and bus-timeout exceptions to CP0.

Parameters:
TIMEOUT, 16, cycles in BUSY without bus_ack before the access is abandoned with a bus-error exception.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_op  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; values 9-15 are treated as none
addr  in  32  byte address (ALU result)
wdata  in  32  store source register value
Req  in  1  exception/interrupt flush from CP0
stall  out  1  freeze PC and the F/D/E/M registers this cycle
dm_out  out  32  extended load data, valid while in DONE
exc_code  out  5  0 none, 4 AdEL, 5 AdES, 7 DBE
bus_req  out  1  bus transaction request
bus_we  out  1  write transaction
bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
bus_byteen  out  4  byte enables
bus_wdata  out  32  lane-shifted store data
bus_ack  in  1  bus completion, one-cycle pulse
bus_rdata  in  32  read data, valid when bus_ack=1

Behaviour:
- States: IDLE, BUSY, DONE, DRAIN.
- Reset (reset=0, asynchronous):
  - state=IDLE; timeout counter=0; all bus_* outputs 0.
  - dm_out=0, exc_code=0, stall=0; all captured registers 0.
- Alignment checks (combinational, IDLE only):
  - AdEL: lw with addr[1:0]≠0, or lh/lhu with addr[0]=1.
  - AdES: sw with addr[1:0]≠0, or sh with addr[0]=1.
  - Byte ops never fault.
  - A faulting op issues no bus request, asserts no stall and leaves state=IDLE; exc_code shows 4 or 5 in that same cycle.
- start = (state==IDLE) && mem_op valid && no alignment fault && !Req.
- IDLE:
  - start=1 → stall=1 this cycle.
  - On the next edge: register op, addr, byteen and shifted wdata; go to BUSY; clear the timeout counter.
- BUSY:
  - bus_req=1; stall=1; bus_we=1 for store ops.
  - Byte enables: sw → 1111; sh → 0011<<addr[1:0]; sb → 0001<<addr[1:0]; loads → 1111.
  - Store data: bus_wdata = wdata replicated into the selected lanes.
  - bus_ack=1 → capture bus_rdata; go to DONE.
  - Otherwise the counter increments; when the counter reaches TIMEOUT-1 without ack → drop bus_req; go to DONE with the timeout flag set.
  - Req=1 while in BUSY → go to DRAIN. The ack is honoured in the same cycle if present; if so, go straight to IDLE instead.
- DONE (exactly 1 cycle):
  - stall=0, so the M/W register captures dm_out.
  - Load extension from the captured addr[1:0]:
    - lw: full word.
    - lh/lhu: halfword selected by addr[1], sign-/zero-extended.
    - lb/lbu: byte selected by addr[1:0], sign-/zero-extended.
  - Stores: dm_out=0.
  - Timeout flag set → exc_code=7 and dm_out=0.
  - No new start is taken in DONE. Next state is IDLE, where the following instruction (now in M) may start.
- DRAIN:
  - bus_req is held until bus_ack or timeout, because the protocol forbids dropping req before ack. stall=1.
  - Read data is discarded; no exception is reported.
  - Req is ignored in this state. On ack or timeout → IDLE.
- Req in IDLE suppresses start; no bus activity occurs.
- bus_addr, bus_we, bus_byteen and bus_wdata stay stable throughout BUSY/DRAIN.
- bus_ack outside BUSY/DRAIN is ignored.
- Ack on the same cycle the counter expires: the ack wins; no exception.
- Reset mid-transaction: bus_req drops immediately and state=IDLE.

Test Plan:
- lw, addr=0x0000_1004; bus_ack 3 cycles after bus_req; bus_rdata=0x8765_4321:
  - stall high for 4 cycles; bus_addr=0x1004, byteen=1111.
  - DONE cycle: dm_out=0x8765_4321, stall=0, exc_code=0.
- lb, addr=0x1002, bus_rdata=0x0080_0000 → dm_out=0xFFFF_FF80. Same stimulus with lbu → dm_out=0x0000_0080.
- sh, addr=0x2002, wdata=0x0000_BEEF → bus_we=1, byteen=1100, bus_wdata[31:16]=0xBEEF; dm_out=0 in DONE.
- lw, addr=0x1001 → exc_code=4 in the same cycle; bus_req never rises; stall=0. sw, addr=0x1002 → exc_code=5.
- Never ack a lw, TIMEOUT=16 → bus_req high for 16 cycles; then DONE with exc_code=7, dm_out=0; then IDLE.
- Req pulse 1 cycle after entering BUSY, ack 2 cycles later:
  - bus_req stays high until the ack; stall=1 throughout; no DONE, exc_code=0; then IDLE.
  - Repeat with reset=0 pulsed mid-BUSY → bus_req=0 asynchronously; state=IDLE.

Source files
------------

// File: rtl/m_mem_access.sv
// M-stage data-memory access unit: turns a load/store into a req/ack bus
// transaction, stalls the pipeline until the bus answers, extends load data.
module m_mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        Req,
    output logic        stall,
    output logic [31:0] dm_out,
    output logic [4:0]  exc_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     op_q, op_d;
    logic [31:0]    addr_q, addr_d;
    logic [3:0]     byteen_q, byteen_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           tmo_q, tmo_d;

    logic           op_valid, adel, ades, start, cnt_max, active;
    logic [3:0]     lane_byteen;
    logic [31:0]    lane_wdata;
    logic [7:0]     rd_byte [4];
    logic [7:0]     sel_byte;
    logic [15:0]    sel_half;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = rdata_q[8*gi +: 8];
    end

    // Alignment check and store-lane preparation on the live M-stage inputs
    always_comb begin
        op_valid    = (mem_op >= OP_LW) && (mem_op <= OP_SB);
        adel        = ((mem_op == OP_LW) && (addr[1:0] != 2'b00)) ||
                      (((mem_op == OP_LH) || (mem_op == OP_LHU)) && addr[0]);
        ades        = ((mem_op == OP_SW) && (addr[1:0] != 2'b00)) ||
                      ((mem_op == OP_SH) && addr[0]);
        start       = (state_q == IDLE) && op_valid && !adel && !ades && !Req;
        lane_byteen = 4'b1111;
        lane_wdata  = 32'd0;
        case (mem_op)
            OP_SW: lane_wdata = wdata;
            OP_SH: begin
                lane_byteen = 4'b0011 << addr[1:0];
                lane_wdata  = {2{wdata[15:0]}};
            end
            OP_SB: begin
                lane_byteen = 4'b0001 << addr[1:0];
                lane_wdata  = {4{wdata[7:0]}};
            end
            default: lane_wdata = 32'd0;
        endcase
    end

    assign cnt_max = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
        byteen_d = byteen_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        tmo_d    = tmo_q;
        stall    = 1'b0;
        exc_code = 5'd0;
        case (state_q)
            IDLE: begin
                if (op_valid && adel) exc_code = 5'd4;
                else if (op_valid && ades) exc_code = 5'd5;
                if (start) begin
                    stall    = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = '0;
                    op_d     = mem_op;
                    addr_d   = addr;
                    byteen_d = lane_byteen;
                    wdata_d  = lane_wdata;
                    tmo_d    = 1'b0;
                end
            end
            BUSY: begin
                stall = 1'b1;
                // A flush that coincides with the ack or the expiry has nothing left to drain
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    state_d = Req ? IDLE : DONE;
                end else if (cnt_max) begin
                    tmo_d   = !Req;
                    state_d = Req ? IDLE : DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (Req) state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (tmo_q) exc_code = 5'd7;
            end
            DRAIN: begin
                stall = 1'b1;
                if (bus_ack || cnt_max) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dm_out   = 32'd0;
        sel_byte = rd_byte[addr_q[1:0]];
        sel_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        if ((state_q == DONE) && !tmo_q) begin
            case (op_q)
                OP_LW:   dm_out = rdata_q;
                OP_LH:   dm_out = {{16{sel_half[15]}}, sel_half};
                OP_LHU:  dm_out = {16'd0, sel_half};
                OP_LB:   dm_out = {{24{sel_byte[7]}}, sel_byte};
                OP_LBU:  dm_out = {24'd0, sel_byte};
                default: dm_out = 32'd0;
            endcase
        end
    end

    // Bus outputs come straight from state flops so reset drops them at once
    assign active     = (state_q == BUSY) || (state_q == DRAIN);
    assign bus_req    = active;
    assign bus_we     = active && (op_q >= OP_SW) && (op_q <= OP_SB);
    assign bus_addr   = active ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_byteen = active ? byteen_q : 4'd0;
    assign bus_wdata  = active ? wdata_q : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 4'd0;
            addr_q   <= 32'd0;
            byteen_q <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            byteen_q <= byteen_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_m_mem_access.sv
// Directed bench for m_mem_access: loads, stores, alignment faults, timeout,
// flush-drain and asynchronous reset, checked with immediate assertions.
module tb_m_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mem_op;
    logic [31:0] addr, wdata;
    logic        Req;
    logic        stall;
    logic [31:0] dm_out;
    logic [4:0]  exc_code;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int n_stall, n_req;
    logic        snap_we;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_byteen;

    m_mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .mem_op(mem_op), .addr(addr), .wdata(wdata),
        .Req(Req), .stall(stall), .dm_out(dm_out), .exc_code(exc_code),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the edge, outputs sampled 1 unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                             input int n_busy, input bit give_ack, input logic [31:0] rd);
        n_stall = 0;
        n_req   = 0;
        cyc();
        mem_op = op; addr = a; wdata = wd;
        #1;
        if (stall) n_stall++;
        for (int i = 1; i <= n_busy; i++) begin
            cyc();
            bus_ack   = give_ack && (i == n_busy);
            bus_rdata = bus_ack ? rd : 32'hDEAD_BEEF;
            #1;
            if (stall) n_stall++;
            if (bus_req) n_req++;
            if (i == n_busy) begin
                snap_we     = bus_we;
                snap_addr   = bus_addr;
                snap_byteen = bus_byteen;
                snap_wdata  = bus_wdata;
            end
        end
        cyc();
        bus_ack = 1'b0; mem_op = 4'd0;
        #1;
        $display("access op=%0d addr=%08h busy=%0d ack=%0d -> dm_out=%08h exc=%0d stall=%0d",
                 op, a, n_busy, give_ack, dm_out, exc_code, stall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; mem_op = 4'd0; addr = 32'd0; wdata = 32'd0;
        Req = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
        #3;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_byteen", {28'd0, bus_byteen}, 32'd0);
        chk("rst_dm", dm_out, 32'd0);
        chk("rst_exc", {27'd0, exc_code}, 32'd0);
        $display("reset state checked");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // lw with ack on the third BUSY cycle
        do_access(4'd1, 32'h0000_1004, 32'd0, 3, 1'b1, 32'h8765_4321);
        chk("lw_stall_cycles", n_stall, 32'd4);
        chk("lw_req_cycles", n_req, 32'd3);
        chk("lw_bus_addr", snap_addr, 32'h0000_1004);
        chk("lw_byteen", {28'd0, snap_byteen}, 32'hF);
        chk("lw_we", {31'd0, snap_we}, 32'd0);
        chk("lw_dm", dm_out, 32'h8765_4321);
        chk("lw_done_stall", {31'd0, stall}, 32'd0);
        chk("lw_done_exc", {27'd0, exc_code}, 32'd0);
        cyc();
        chk("lw_idle_req", {31'd0, bus_req}, 32'd0);

        do_access(4'd4, 32'h0000_1002, 32'd0, 1, 1'b1, 32'h0080_0000);
        chk("lb_dm", dm_out, 32'hFFFF_FF80);
        do_access(4'd5, 32'h0000_1002, 32'd0, 1, 1'b1, 32'h0080_0000);
        chk("lbu_dm", dm_out, 32'h0000_0080);
        do_access(4'd2, 32'h0000_1002, 32'd0, 2, 1'b1, 32'h8001_1234);
        chk("lh_dm", dm_out, 32'hFFFF_8001);
        do_access(4'd3, 32'h0000_1000, 32'd0, 1, 1'b1, 32'h1234_9ABC);
        chk("lhu_dm", dm_out, 32'h0000_9ABC);
        do_access(4'd4, 32'h0000_1003, 32'd0, 1, 1'b1, 32'h7F00_0000);
        chk("lb_odd_dm", dm_out, 32'h0000_007F);

        // Stores
        do_access(4'd7, 32'h0000_2002, 32'h0000_BEEF, 2, 1'b1, 32'hFFFF_FFFF);
        chk("sh_we", {31'd0, snap_we}, 32'd1);
        chk("sh_byteen", {28'd0, snap_byteen}, 32'hC);
        chk("sh_wdata_hi", {16'd0, snap_wdata[31:16]}, 32'h0000_BEEF);
        chk("sh_bus_addr", snap_addr, 32'h0000_2000);
        chk("sh_dm", dm_out, 32'd0);
        do_access(4'd8, 32'h0000_3001, 32'h1234_5678, 1, 1'b1, 32'd0);
        chk("sb_byteen", {28'd0, snap_byteen}, 32'h2);
        chk("sb_lane", {24'd0, snap_wdata[15:8]}, 32'h78);
        do_access(4'd6, 32'h0000_3008, 32'hCAFE_F00D, 1, 1'b1, 32'd0);
        chk("sw_wdata", snap_wdata, 32'hCAFE_F00D);
        chk("sw_byteen", {28'd0, snap_byteen}, 32'hF);

        // Alignment faults
        cyc();
        mem_op = 4'd1; addr = 32'h0000_1001;
        #1;
        chk("adel_exc", {27'd0, exc_code}, 32'd4);
        chk("adel_stall", {31'd0, stall}, 32'd0);
        cyc();
        chk("adel_req", {31'd0, bus_req}, 32'd0);
        mem_op = 4'd6; addr = 32'h0000_1002;
        #1;
        chk("ades_exc", {27'd0, exc_code}, 32'd5);
        chk("ades_stall", {31'd0, stall}, 32'd0);
        cyc();
        chk("ades_req", {31'd0, bus_req}, 32'd0);
        mem_op = 4'd0;
        $display("alignment faults checked");

        // Timeout, then ack exactly at expiry
        do_access(4'd1, 32'h0000_0010, 32'd0, 16, 1'b0, 32'd0);
        chk("tmo_req_cycles", n_req, 32'd16);
        chk("tmo_exc", {27'd0, exc_code}, 32'd7);
        chk("tmo_dm", dm_out, 32'd0);
        chk("tmo_stall", {31'd0, stall}, 32'd0);
        cyc();
        chk("tmo_idle_exc", {27'd0, exc_code}, 32'd0);
        chk("tmo_idle_req", {31'd0, bus_req}, 32'd0);
        do_access(4'd1, 32'h0000_0010, 32'd0, 16, 1'b1, 32'h5555_AAAA);
        chk("late_ack_exc", {27'd0, exc_code}, 32'd0);
        chk("late_ack_dm", dm_out, 32'h5555_AAAA);

        // Flush during BUSY: drain until ack, no DONE
        cyc();
        mem_op = 4'd1; addr = 32'h0000_4000;
        cyc();
        cyc();
        Req = 1'b1; mem_op = 4'd0;
        cyc();
        Req = 1'b0;
        #1;
        chk("drain1_req", {31'd0, bus_req}, 32'd1);
        chk("drain1_stall", {31'd0, stall}, 32'd1);
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        #1;
        chk("drain2_req", {31'd0, bus_req}, 32'd1);
        chk("drain2_stall", {31'd0, stall}, 32'd1);
        chk("drain2_exc", {27'd0, exc_code}, 32'd0);
        cyc();
        bus_ack = 1'b0;
        #1;
        chk("drain_idle_req", {31'd0, bus_req}, 32'd0);
        chk("drain_idle_stall", {31'd0, stall}, 32'd0);
        chk("drain_idle_dm", dm_out, 32'd0);
        $display("flush drain checked");

        // Req in IDLE suppresses start
        cyc();
        mem_op = 4'd1; addr = 32'h0000_5000; Req = 1'b1;
        #1;
        chk("req_idle_stall", {31'd0, stall}, 32'd0);
        cyc();
        chk("req_idle_req", {31'd0, bus_req}, 32'd0);
        mem_op = 4'd0; Req = 1'b0;

        // Asynchronous reset mid-BUSY
        cyc();
        mem_op = 4'd1; addr = 32'h0000_6000;
        cyc();
        mem_op = 4'd0;
        #1;
        chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, bus_req}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        #1 reset = 1'b1;
        cyc();
        chk("post_rst_req", {31'd0, bus_req}, 32'd0);
        $display("async reset checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
